scene_sequencer: RTL
====================

SCENE_SEQUENCER -- requirements
Module: scene_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT_FRAMES, default 120, giving the number of frames OVER is held before returning to MENU (legal 1..254).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port frame_begin, input, 1, one-cycle pulse at the start of each OLED frame.
REQ-005 The block SHALL have port btn_c, input, 1, one-cycle debounced centre-button pulse.
REQ-006 The block SHALL have port btn_u, input, 1, one-cycle debounced up-button pulse.
REQ-007 The block SHALL have port lose, input, 1, level from game logic, high when the game is lost.
REQ-008 The block SHALL have ports menu_data, play_data and over_data, each input, 16, RGB565 pixel from the respective renderer for the current (x,y).
REQ-009 The block SHALL have port oled_data, output, 16, registered RGB565 pixel to the OLED driver.
REQ-010 The block SHALL have port scene, output, 2, current scene: MENU=0, PLAY=1, PAUSE=2, OVER=3.
REQ-011 The block SHALL have port play_en, output, 1, high only while scene==PLAY.

Function
REQ-012 Scene FSM states SHALL be MENU, PLAY, PAUSE and OVER; scene changes take effect only on a frame_begin cycle, so no frame is torn.
REQ-013 Requests SHALL be: MENU+btn_c->PLAY; PLAY+btn_c->PAUSE; PLAY+lose->OVER; PAUSE+btn_c->PLAY; PAUSE+btn_u->MENU; OVER+btn_c->MENU; OVER+timeout->MENU.
REQ-014 Requests SHALL be evaluated against the current scene, not the pending one.
REQ-015 A request SHALL set pend_valid=1 and pend_scene, with priority lose > btn_c > btn_u > timeout within one cycle.
REQ-016 While pend_valid=1, further requests SHALL be ignored, except a lose request in PLAY, which overwrites pend_scene with OVER.
REQ-017 On a cycle with frame_begin=1 and pend_valid=1: scene<=pend_scene, pend_valid<=0, frame_cnt<=0.
REQ-018 A request arriving in the same cycle as frame_begin SHALL be latched and applied at the next frame_begin, not the current one.
REQ-019 frame_cnt SHALL be 8-bit, increment on each frame_begin not applying a scene change, saturate at 255 and never wrap.
REQ-020 The timeout request SHALL be raised when scene==OVER, frame_cnt==TIMEOUT_FRAMES and pend_valid=0; it is then applied at the following frame_begin.
REQ-021 The PAUSE exit request SHALL use the button priority of REQ-015; btn_c and btn_u together in PAUSE yield PLAY.
REQ-022 oled_data SHALL be registered with 1-cycle latency from the pixel inputs, selected by the scene register value in the same cycle.
REQ-023 oled_data SHALL be menu_data in MENU, play_data in PLAY, over_data in OVER, and in PAUSE (play_data>>1)&16'h7BEF (half brightness per channel).
REQ-024 play_en SHALL be a decode of the scene register, with no extra latency.
REQ-025 lose SHALL be ignored in every scene other than PLAY.

Reset
REQ-026 While reset=1 at a clk edge, the block SHALL set scene=MENU, pend_valid=0, pend_scene=MENU, frame_cnt=0, oled_data=16'h0000 and play_en=0.
REQ-027 Reset SHALL override all other inputs in the same cycle, including frame_begin and button pulses, and discard any pending request.
REQ-028 The first frame_begin after reset deassertion SHALL increment frame_cnt from 0 to 1 and leave scene=MENU.

Verification
REQ-029 Scenario: reset, then btn_c pulse, then frame_begin 10 cycles later -> scene stays 0 until the frame_begin edge, then scene=1 and play_en=1.
REQ-030 Scenario: in PLAY, btn_c and frame_begin in the same cycle -> scene stays 1 for that frame; at the next frame_begin scene=2, and play_data=16'hFFFF gives oled_data=16'h7BEF one cycle later.
REQ-031 Scenario: in PLAY, btn_c pulse, then lose=1 before frame_begin -> at frame_begin scene=3, not 2.
REQ-032 Scenario: in OVER with TIMEOUT_FRAMES=3 and no buttons -> timeout request raised when frame_cnt reaches 3; scene=0 at the 4th frame_begin after entry.
REQ-033 Scenario: in PAUSE, btn_u and btn_c in the same cycle, then frame_begin -> scene=1; a later btn_u in PAUSE with frame_begin -> scene=0.
REQ-034 Scenario: reset asserted with pend_valid=1 and frame_begin=1 in the same cycle -> scene=0, pend_valid=0, oled_data=16'h0000; 300 frame_begins in MENU -> frame_cnt=255.

Source files
------------

// File: rtl/scene_sequencer.sv
// Scene sequencer: MENU/PLAY/PAUSE/OVER FSM whose scene changes land only on frame_begin; registered pixel mux to the OLED.
// Latency: oled_data 1 cycle after pixel inputs, play_en combinational from scene; no backpressure (pulse inputs, outputs always valid).
module scene_sequencer #(
   parameter int unsigned TIMEOUT_FRAMES = 120
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_begin,
   input  logic        btn_c,
   input  logic        btn_u,
   input  logic        lose,
   input  logic [15:0] menu_data,
   input  logic [15:0] play_data,
   input  logic [15:0] over_data,
   output logic [15:0] oled_data,
   output logic [1:0]  scene,
   output logic        play_en
);

   typedef enum logic [1:0] {
      S_MENU  = 2'd0,
      S_PLAY  = 2'd1,
      S_PAUSE = 2'd2,
      S_OVER  = 2'd3
   } scene_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_FRAMES);

   scene_t      cur_scene;
   scene_t      nxt_scene;
   scene_t      pend_scene;
   scene_t      nxt_pend_scene;
   logic        pend_valid;
   logic        nxt_pend_valid;
   logic [7:0]  frame_cnt;
   logic [7:0]  nxt_frame_cnt;

   logic        lose_req;
   logic        timeout_req;
   logic        req_vld;
   scene_t      req_scene;
   logic [15:0] pix_sel;

   // Requests are judged against the scene on screen, never the pending one.
   always_comb begin
      lose_req    = (cur_scene == S_PLAY) && lose;
      timeout_req = (cur_scene == S_OVER) && (frame_cnt == TIMEOUT_CNT) && !pend_valid;
      req_vld     = 1'b0;
      req_scene   = S_MENU;
      if (lose_req) begin
         req_vld   = 1'b1;
         req_scene = S_OVER;
      end else if (btn_c) begin
         req_vld = 1'b1;
         case (cur_scene)
            S_MENU:  req_scene = S_PLAY;
            S_PLAY:  req_scene = S_PAUSE;
            S_PAUSE: req_scene = S_PLAY;
            default: req_scene = S_MENU;
         endcase
      end else if (btn_u && (cur_scene == S_PAUSE)) begin
         req_vld   = 1'b1;
         req_scene = S_MENU;
      end else if (timeout_req) begin
         req_vld   = 1'b1;
         req_scene = S_MENU;
      end
   end

   // An apply cycle consumes the pending request and takes no new one, so a
   // request coinciding with frame_begin waits for the following frame.
   always_comb begin
      nxt_scene      = cur_scene;
      nxt_pend_valid = pend_valid;
      nxt_pend_scene = pend_scene;
      nxt_frame_cnt  = frame_cnt;
      if (frame_begin && pend_valid) begin
         nxt_scene      = pend_scene;
         nxt_pend_valid = 1'b0;
         nxt_frame_cnt  = 8'd0;
      end else begin
         if (frame_begin && (frame_cnt != 8'hFF)) begin
            nxt_frame_cnt = frame_cnt + 8'd1;
         end
         if (!pend_valid && req_vld) begin
            nxt_pend_valid = 1'b1;
            nxt_pend_scene = req_scene;
         end else if (pend_valid && lose_req) begin
            nxt_pend_scene = S_OVER;
         end
      end
   end

   always_comb begin
      pix_sel = menu_data;
      case (cur_scene)
         S_MENU:  pix_sel = menu_data;
         S_PLAY:  pix_sel = play_data;
         S_PAUSE: pix_sel = (play_data >> 1) & 16'h7BEF;
         default: pix_sel = over_data;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_scene  <= S_MENU;
         pend_valid <= 1'b0;
         pend_scene <= S_MENU;
         frame_cnt  <= 8'd0;
         oled_data  <= 16'h0000;
      end else begin
         cur_scene  <= nxt_scene;
         pend_valid <= nxt_pend_valid;
         pend_scene <= nxt_pend_scene;
         frame_cnt  <= nxt_frame_cnt;
         oled_data  <= pix_sel;
      end
   end

   assign scene   = cur_scene;
   assign play_en = (cur_scene == S_PLAY);

endmodule
